// File: rtl/mips_pkg.sv
// Constants shared by the hazard/forwarding unit and the EX-stage operand muxes.
// The forward-select encoding here is what the EX mux decode expects.
package mips_pkg;

  localparam int REG_W_DEF = 5;
  localparam int N_STG_DEF = 3;

  // Forward-select encoding: 0 is the register file, FWD_STG0 + i is stage i.
  localparam int FWD_RF   = 0;
  localparam int FWD_STG0 = 1;

  function automatic int md_cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode/execute/downstream-stage signals seen by the hazard and forwarding unit.
// The pipeline drives through master; the unit attaches through slave.
interface hazard_forward_unit_if #(
  parameter int REG_W = mips_pkg::REG_W_DEF,
  parameter int N_STG = mips_pkg::N_STG_DEF,
  parameter int SEL_W = 2,
  parameter int CNT_W = 32
);

  logic [REG_W-1:0]       id_rs;
  logic [REG_W-1:0]       id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic                   id_is_md;
  logic                   id_reads_hilo;
  logic [REG_W-1:0]       ex_rs;
  logic [REG_W-1:0]       ex_rt;
  logic [REG_W-1:0]       ex_rd;
  logic                   ex_wb;
  logic                   ex_is_load;
  logic [N_STG*REG_W-1:0] stg_rd;
  logic [N_STG-1:0]       stg_wb;
  logic                   flush;
  logic [SEL_W-1:0]       forward_a;
  logic [SEL_W-1:0]       forward_b;
  logic                   stall;
  logic                   bubble;
  logic                   md_busy;
  logic [CNT_W-1:0]       stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo,
    output ex_rs, ex_rt, ex_rd, ex_wb, ex_is_load, stg_rd, stg_wb, flush,
    input  forward_a, forward_b, stall, bubble, md_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo,
    input  ex_rs, ex_rt, ex_rd, ex_wb, ex_is_load, stg_rd, stg_wb, flush,
    output forward_a, forward_b, stall, bubble, md_busy, stall_count
  );

endinterface

// File: rtl/fwd_sel.sv
// Priority matcher choosing the youngest downstream stage that writes src.
// One instance per operand keeps the A and B paths structurally identical.
module fwd_sel
  import mips_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int N_STG = N_STG_DEF,
  parameter int SEL_W = 2
) (
  input  logic [REG_W-1:0]       src,
  input  logic [N_STG*REG_W-1:0] stg_rd,
  input  logic [N_STG-1:0]       stg_wb,
  output logic [SEL_W-1:0]       sel
);

  // NOTE: sel gets its default before the loop so this block can never infer a latch.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    // Scan oldest to youngest so the youngest match is the last assignment.
    for (int i = N_STG - 1; i >= 0; i--) begin
      if (stg_wb[i] && (stg_rd[i*REG_W +: REG_W] != '0) &&
          (stg_rd[i*REG_W +: REG_W] == src)) begin
        sel = SEL_W'(FWD_STG0 + i);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand bypass selection, load-use and mult/div hazard control for the ID/EX
// boundary, plus a saturating count of stalled cycles.
module hazard_forward_unit
  import mips_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int N_STG  = N_STG_DEF,
  parameter int SEL_W  = 2,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_unit_if.slave bus
);

  localparam int MD_W = md_cnt_width(MD_LAT);

  logic [MD_W-1:0]  md_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;
  logic             md_busy;
  logic             md_hz;
  logic             stall;
  logic             md_issue;

  fwd_sel #(.REG_W(REG_W), .N_STG(N_STG), .SEL_W(SEL_W)) u_fwd_a (
    .src    (bus.ex_rs),
    .stg_rd (bus.stg_rd),
    .stg_wb (bus.stg_wb),
    .sel    (bus.forward_a)
  );

  fwd_sel #(.REG_W(REG_W), .N_STG(N_STG), .SEL_W(SEL_W)) u_fwd_b (
    .src    (bus.ex_rt),
    .stg_rd (bus.stg_rd),
    .stg_wb (bus.stg_wb),
    .sel    (bus.forward_b)
  );

  // A load in ID/EX cannot be bypassed to the instruction right behind it.
  assign lu = bus.ex_is_load && bus.ex_wb && (bus.ex_rd != '0) &&
              ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
               (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

  assign md_busy  = (md_cnt != '0);
  assign md_hz    = md_busy && (bus.id_reads_hilo || bus.id_is_md);
  assign stall    = !bus.flush && (lu || md_hz);
  assign md_issue = bus.id_is_md && !stall && !bus.flush;

  assign bus.stall       = stall;
  assign bus.bubble      = stall || bus.flush;
  assign bus.md_busy     = md_busy;
  assign bus.stall_count = stall_cnt;

  // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
  // Flush leaves an in-flight operation counting; only reset abandons it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_issue) begin
      md_cnt <= MD_W'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Table-driven and sequence checks of hazard_forward_unit with a queue scoreboard;
// a second instance with a 4-bit stall counter exercises saturation.
module tb_hazard_forward_unit;

  localparam int REG_W  = 5;
  localparam int N_STG  = 3;
  localparam int SEL_W  = 2;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 32;
  localparam int SAT_W  = 4;

  typedef struct {
    string                  name;
    logic [REG_W-1:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd;
    logic                   id_uses_rs, id_uses_rt, id_is_md, id_reads_hilo;
    logic                   ex_wb, ex_is_load, flush;
    logic [N_STG*REG_W-1:0] stg_rd;
    logic [N_STG-1:0]       stg_wb;
    logic [SEL_W-1:0]       fa, fb;
    logic                   stall, bubble, busy;
  } vec_t;

  typedef struct {
    string            name;
    logic [SEL_W-1:0] fa, fb;
    logic             stall, bubble, busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[$];
  logic [CNT_W-1:0] model_cnt;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_W(REG_W), .N_STG(N_STG), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();
  hazard_forward_unit_if #(.REG_W(REG_W), .N_STG(N_STG), .SEL_W(SEL_W), .CNT_W(SAT_W)) sbus ();

  hazard_forward_unit #(
    .REG_W(REG_W), .N_STG(N_STG), .SEL_W(SEL_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hazard_forward_unit #(
    .REG_W(REG_W), .N_STG(N_STG), .SEL_W(SEL_W), .MD_LAT(MD_LAT), .CNT_W(SAT_W)
  ) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  assign sbus.id_rs         = bus.id_rs;
  assign sbus.id_rt         = bus.id_rt;
  assign sbus.id_uses_rs    = bus.id_uses_rs;
  assign sbus.id_uses_rt    = bus.id_uses_rt;
  assign sbus.id_is_md      = bus.id_is_md;
  assign sbus.id_reads_hilo = bus.id_reads_hilo;
  assign sbus.ex_rs         = bus.ex_rs;
  assign sbus.ex_rt         = bus.ex_rt;
  assign sbus.ex_rd         = bus.ex_rd;
  assign sbus.ex_wb         = bus.ex_wb;
  assign sbus.ex_is_load    = bus.ex_is_load;
  assign sbus.stg_rd        = bus.stg_rd;
  assign sbus.stg_wb        = bus.stg_wb;
  assign sbus.flush         = bus.flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t nv(input string name);
    vec_t v;
    v.name = name;
    v.id_rs = '0; v.id_rt = '0; v.ex_rs = '0; v.ex_rt = '0; v.ex_rd = '0;
    v.id_uses_rs = 1'b0; v.id_uses_rt = 1'b0; v.id_is_md = 1'b0; v.id_reads_hilo = 1'b0;
    v.ex_wb = 1'b0; v.ex_is_load = 1'b0; v.flush = 1'b0;
    v.stg_rd = '0; v.stg_wb = '0;
    v.fa = '0; v.fb = '0; v.stall = 1'b0; v.bubble = 1'b0; v.busy = 1'b0;
    return v;
  endfunction

  function automatic logic [N_STG*REG_W-1:0] rd3(input logic [REG_W-1:0] s2, s1, s0);
    return {s2, s1, s0};
  endfunction

  function automatic vec_t lu_vec(input string name);
    vec_t v = nv(name);
    v.ex_is_load = 1'b1; v.ex_wb = 1'b1; v.ex_rd = 5'd9;
    v.id_rt = 5'd9; v.id_uses_rt = 1'b1;
    v.stall = 1'b1; v.bubble = 1'b1;
    return v;
  endfunction

  function automatic vec_t mdv(input string name, input logic is_md, hilo, fl, lu,
                               input logic st, bu, busy);
    vec_t v = lu ? lu_vec(name) : nv(name);
    v.id_is_md = is_md; v.id_reads_hilo = hilo; v.flush = fl;
    v.stall = st; v.bubble = bu; v.busy = busy;
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    bus.id_rs = v.id_rs; bus.id_rt = v.id_rt;
    bus.id_uses_rs = v.id_uses_rs; bus.id_uses_rt = v.id_uses_rt;
    bus.id_is_md = v.id_is_md; bus.id_reads_hilo = v.id_reads_hilo;
    bus.ex_rs = v.ex_rs; bus.ex_rt = v.ex_rt; bus.ex_rd = v.ex_rd;
    bus.ex_wb = v.ex_wb; bus.ex_is_load = v.ex_is_load;
    bus.stg_rd = v.stg_rd; bus.stg_wb = v.stg_wb; bus.flush = v.flush;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    set_inputs(v);
    e.name = v.name; e.fa = v.fa; e.fb = v.fb;
    e.stall = v.stall; e.bubble = v.bubble; e.busy = v.busy; e.cnt = model_cnt;
    sb.push_back(e);
    if (v.stall && (model_cnt != '1)) model_cnt = model_cnt + 1;
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ":forward_a"},   32'(bus.forward_a),   32'(e.fa));
      check({e.name, ":forward_b"},   32'(bus.forward_b),   32'(e.fb));
      check({e.name, ":stall"},       32'(bus.stall),       32'(e.stall));
      check({e.name, ":bubble"},      32'(bus.bubble),      32'(e.bubble));
      check({e.name, ":md_busy"},     32'(bus.md_busy),     32'(e.busy));
      check({e.name, ":stall_count"}, 32'(bus.stall_count), 32'(e.cnt));
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    sample();
  endtask

  task automatic check_reset_state(input string name);
    check({name, ":md_busy"},     32'(bus.md_busy),      32'd0);
    check({name, ":stall_count"}, 32'(bus.stall_count),  32'd0);
    check({name, ":sat_count"},   32'(sbus.stall_count), 32'd0);
    check({name, ":stall"},       32'(bus.stall),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset = 1'b0;
    model_cnt = '0;
    set_inputs(nv("idle"));
    #1 reset = 1'b1;
    #2;
    check_reset_state("reset");
    check("reset:bubble", 32'(bus.bubble), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Combinational forwarding and load-use vectors.
    v = nv("fwd_youngest"); v.ex_rs = 5'd5; v.stg_rd = rd3(0, 5, 5); v.stg_wb = 3'b011; v.fa = 2'd1; tbl.push_back(v);
    v = nv("fwd_drop_stg0"); v.ex_rs = 5'd5; v.stg_rd = rd3(0, 5, 5); v.stg_wb = 3'b010; v.fa = 2'd2; tbl.push_back(v);
    v = nv("fwd_rd_zero"); v.ex_rs = 5'd5; v.stg_rd = rd3(0, 0, 0); v.stg_wb = 3'b111; tbl.push_back(v);
    v = nv("fwd_r0_src"); v.stg_rd = rd3(0, 0, 0); v.stg_wb = 3'b111; tbl.push_back(v);
    v = nv("fwd_b_stg2"); v.ex_rs = 5'd3; v.ex_rt = 5'd7; v.stg_rd = rd3(7, 1, 2); v.stg_wb = 3'b100; v.fb = 2'd3; tbl.push_back(v);
    v = nv("fwd_ab_same"); v.ex_rs = 5'd4; v.ex_rt = 5'd4; v.stg_rd = rd3(4, 4, 9); v.stg_wb = 3'b111; v.fa = 2'd2; v.fb = 2'd2; tbl.push_back(v);
    v = nv("fwd_no_wb"); v.ex_rs = 5'd6; v.ex_rt = 5'd6; v.stg_rd = rd3(6, 6, 6); v.stg_wb = 3'b000; tbl.push_back(v);
    v = nv("fwd_mixed"); v.ex_rs = 5'd10; v.ex_rt = 5'd11; v.stg_rd = rd3(10, 11, 10); v.stg_wb = 3'b111; v.fa = 2'd1; v.fb = 2'd2; tbl.push_back(v);
    v = lu_vec("lu_rt"); tbl.push_back(v);
    v = lu_vec("lu_rt_unused"); v.id_uses_rt = 1'b0; v.stall = 1'b0; v.bubble = 1'b0; tbl.push_back(v);
    v = lu_vec("lu_rs"); v.id_uses_rt = 1'b0; v.id_rs = 5'd9; v.id_uses_rs = 1'b1; tbl.push_back(v);
    v = lu_vec("lu_rd_zero"); v.ex_rd = 5'd0; v.id_rt = 5'd0; v.stall = 1'b0; v.bubble = 1'b0; tbl.push_back(v);
    v = lu_vec("lu_no_wb"); v.ex_wb = 1'b0; v.stall = 1'b0; v.bubble = 1'b0; tbl.push_back(v);
    v = lu_vec("lu_not_load"); v.ex_is_load = 1'b0; v.stall = 1'b0; v.bubble = 1'b0; tbl.push_back(v);
    v = lu_vec("lu_flush"); v.flush = 1'b1; v.stall = 1'b0; v.bubble = 1'b1; tbl.push_back(v);
    v = nv("flush_only"); v.flush = 1'b1; v.bubble = 1'b1; tbl.push_back(v);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Load-use: one stall cycle, then the load is bypassed from stage 0, then stage 1.
    step(lu_vec("lu_seq_stall"));
    v = nv("lu_seq_stg0"); v.id_rt = 5'd9; v.id_uses_rt = 1'b1; v.ex_rt = 5'd9;
    v.stg_rd = rd3(0, 0, 9); v.stg_wb = 3'b001; v.fb = 2'd1; step(v);
    v = nv("lu_seq_stg1"); v.ex_rt = 5'd9; v.stg_rd = rd3(0, 9, 0); v.stg_wb = 3'b010; v.fb = 2'd2; step(v);

    // mult then mfhi: stalled for MD_LAT cycles, proceeds on the next one.
    step(mdv("md1_issue", 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < MD_LAT; i++) step(mdv("md1_mfhi_wait", 0, 1, 0, 0, 1, 1, 1));
    step(mdv("md1_mfhi_go", 0, 1, 0, 0, 0, 0, 0));

    // Back-to-back md, overlap with load-use, flush during busy, flushed issue.
    step(mdv("md2_issue",     1, 0, 0, 0, 0, 0, 0));
    step(mdv("md2_wait",      1, 0, 0, 0, 1, 1, 1));
    step(mdv("md2_wait_lu",   1, 0, 0, 1, 1, 1, 1));
    step(mdv("md2_flush",     1, 0, 1, 0, 0, 1, 1));
    step(mdv("md2_wait_last", 1, 0, 0, 0, 1, 1, 1));
    step(mdv("md2_reissue",   1, 0, 0, 0, 0, 0, 0));
    step(mdv("md2_busy",      0, 0, 0, 0, 0, 0, 1));
    step(mdv("md2_busy_fl",   0, 0, 1, 0, 0, 1, 1));
    step(mdv("md2_busy",      0, 0, 0, 0, 0, 0, 1));
    step(mdv("md2_busy",      0, 0, 0, 0, 0, 0, 1));
    step(mdv("md2_drained",   0, 0, 0, 0, 0, 0, 0));
    step(mdv("md_flush_iss",  1, 0, 1, 0, 0, 1, 0));
    step(mdv("md_not_issued", 0, 0, 0, 0, 0, 0, 0));

    // Reset between clock edges while mfhi waits on a pending result.
    step(mdv("rst_md_issue", 1, 0, 0, 0, 0, 0, 0));
    step(mdv("rst_md_wait",  0, 1, 0, 0, 1, 1, 1));
    #1 reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_cnt = '0;
    set_inputs(nv("idle"));
    @(negedge clk);
    reset = 1'b0;
    step(mdv("post_reset", 0, 1, 0, 0, 0, 0, 0));

    // Hold a load-use stall for 20 cycles; the 4-bit counter stops at 15.
    for (int i = 0; i < 20; i++) begin
      step(lu_vec("sat_stall"));
      check("sat_count", 32'(sbus.stall_count), (i > 15) ? 32'd15 : 32'(i));
    end
    step(nv("sat_after"));
    check("sat_final", 32'(sbus.stall_count), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard-control block for the pipelined MIPS core. It sits beside the ID/EX register. It selects an operand bypass source from up to N_STG downstream pipeline stages, youngest stage first. It detects load-use hazards and holds decode while a multi-cycle mult/div unit is busy. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_W, 5: register-address width.
- N_STG, 3: number of forwarding stages. Stage 0 = EX/MEM, 1 = MEM/WB, 2 = WB-late.
- SEL_W, 2: forward-select width. Must satisfy 2^SEL_W ≥ N_STG+1.
- MD_LAT, 4: mult/div latency in cycles, ≥1.
- CNT_W, 32: stall-counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  REG_W  source registers of the instruction in decode
- id_uses_rs, id_uses_rt  in  1  decode instruction actually reads rs / rt
- id_is_md  in  1  decode instruction is mult/multu/div/divu
- id_reads_hilo  in  1  decode instruction is mfhi/mflo
- ex_rs, ex_rt  in  REG_W  ID/EX source registers
- ex_rd  in  REG_W  ID/EX destination
- ex_wb, ex_is_load  in  1  ID/EX writes a GPR / is a load
- stg_rd  in  N_STG*REG_W  packed destinations; stage i occupies bits [i*REG_W +: REG_W]
- stg_wb  in  N_STG  per-stage register-write enable
- flush  in  1  pipeline flush (branch/exception); decode instruction discarded
- forward_a, forward_b  out  SEL_W  0 = register file, k = stage k-1
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX control fields
- md_busy  out  1  mult/div result pending
- stall_count  out  CNT_W  cycles with stall=1

## Operation
- Forwarding (combinational), applied independently for A (ex_rs) and B (ex_rt):
  - Stage i qualifies when stg_wb[i] && stg_rd[i] != 0 && stg_rd[i] == src.
  - Output = 1 + lowest qualifying i; 0 if none qualifies.
  - Youngest stage always wins. A and B use identical priority; no asymmetry.
- Load-use hazard: lu = ex_is_load && ex_wb && ex_rd != 0 && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd)).
- MD scoreboard: registered counter md_cnt, width clog2(MD_LAT+1).
  - md_busy = (md_cnt != 0).
  - md_hz = md_busy && (id_reads_hilo || id_is_md).
- stall = !flush && (lu || md_hz). bubble = stall || flush.
- md_cnt update, in priority order:
  - Load MD_LAT when id_is_md && !stall && !flush (issue accepted).
  - Otherwise decrement when nonzero.
  - Otherwise hold.
- flush does not cancel an in-flight md operation; md_cnt keeps counting.
- stall_count increments by 1 each cycle stall=1 and saturates at all-ones.

## Timing
- forward_a/b, stall, bubble: zero-latency combinational from inputs and md_cnt.
- Load-use: exactly one stall cycle per hazard. The next cycle the load is in stage 0 and forward selects 1.
- Reset: md_cnt=0 and stall_count=0 immediately, asynchronously. Consequently md_busy=0, and stall=0 when no lu is present.
- Reset mid-MD: pending result abandoned, md_busy falls on assertion.
- md issued at cycle t: md_busy=1 during t+1..t+MD_LAT. An mfhi in decode at t+MD_LAT+1 proceeds without stall.
- A second md arriving while busy stalls until md_cnt==0, then issues.
- Simultaneous lu and md_hz: single stall, no double count.

## Structure
- Shared package mips_pkg holds FWD_RF=0, FWD_STG0=1 and default REG_W/N_STG constants. The mux decode in the EX stage consumes the same constants.
- Sub-module fwd_sel (one instance per operand): parametrised priority matcher over N_STG stages. Keeps A/B logic identical.
- Scoreboard counter and stall counter live in the top module.

## Test plan
- ex_rs=5; stg_rd stage0=5, stage1=5, both wb=1 -> forward_a=1. Drop stage0 wb -> 2. Set rd=0 in all stages -> 0.
- ex_rt=7; stage2 only matching (wb=1) -> forward_b=3, forward_a unaffected (0).
- ex_is_load=1, ex_wb=1, ex_rd=9; id_rt=9 with id_uses_rt=1 -> stall=1, bubble=1 for one cycle. With id_uses_rt=0 -> no stall.
- MD_LAT=4: issue mult at t, mfhi at t+1 -> stall t+1..t+4, proceeds t+5. stall_count advances by 4.
- md issued, reset asserted mid-count -> md_busy=0 and stall_count=0 asynchronously. Same-cycle flush with a load-use hazard -> stall=0, bubble=1.
- CNT_W=4: hold stall 20 cycles -> stall_count saturates at 15.
